// File: rtl/jtframe_hfir.sv
// ---------------------------------------------------------------------------
// jtframe_hfir -- parametrised horizontal FIR video filter
//
// Sits between the core colour mixer and the scan doubler / scaler. Each
// colour channel keeps an N-sample history of the incoming pixels. On every
// pxl_cen a serial multiply-accumulate runs over the N taps, one tap per clk,
// using one multiplier and one accumulator per channel. N+1 clk after the
// input strobe the scaled and saturated result appears on rgb_out together
// with a one-clk pxl_out strobe. Output sample k is centred on input sample
// k-(N-1)/2. HS/VS/LHBL are delayed by the same number of samples.
//
// Line edges are clamped so that blanked pixels never leak into the picture:
//   - first active sample after blank fills the whole history,
//   - during blank tap 0 repeats the last value instead of taking din.
//
// A pxl_cen that lands while the MAC is still running abandons the running
// computation (no strobe for it), starts the new one and sets the sticky ovr
// flag.
//
// Optional build macro: JTFRAME_HFIR_SHADOW_EN
//   defined   : coefficient writes go to a shadow bank, copied to the active
//               bank on the clk that sees a VS_in rising edge.
//   undefined : writes wait in a one-entry pending register and are applied
//               at the next pxl_cen, so coefficients never change mid-MAC.
//
// Ports
//   rst        in   asynchronous reset, active high
//   clk        in   system clock
//   pxl_cen    in   input sample strobe (>= N+1 clk apart)
//   enable     in   1 = filter, 0 = bypass (latched at pxl_cen)
//   rgb_in     in   CH*WIN packed pixel, channel 0 in the LSBs
//   HS_in      in   horizontal sync
//   VS_in      in   vertical sync
//   LHBL_in    in   horizontal blank, active low
//   coef_we    in   coefficient write strobe
//   coef_addr  in   tap index (values >= N are ignored)
//   coef_din   in   coefficient value (unsigned, WC bits)
//   pxl_out    out  output sample strobe, one clk wide
//   rgb_out    out  CH*WOUT filtered pixel
//   HS_out     out  aligned HS
//   VS_out     out  aligned VS
//   LHBL_out   out  aligned blank (0 after reset)
//   ovr        out  sticky overrun flag
// ---------------------------------------------------------------------------
module jtframe_hfir #(
  parameter int              WIN   = 4,
  parameter int              WOUT  = 6,
  parameter int              WC    = 5,
  parameter int              N     = 5,
  parameter int              CH    = 3,
  parameter logic [N*WC-1:0] COEFF = {5'd0, 5'd7, 5'd20, 5'd7, 5'd0}
) (
  input  logic                 rst,
  input  logic                 clk,
  input  logic                 pxl_cen,
  input  logic                 enable,
  input  logic [CH*WIN-1:0]    rgb_in,
  input  logic                 HS_in,
  input  logic                 VS_in,
  input  logic                 LHBL_in,
  input  logic                 coef_we,
  input  logic [$clog2(N)-1:0] coef_addr,
  input  logic [WC-1:0]        coef_din,
  output logic                 pxl_out,
  output logic [CH*WOUT-1:0]   rgb_out,
  output logic                 HS_out,
  output logic                 VS_out,
  output logic                 LHBL_out,
  output logic                 ovr
);

  // Accumulator cannot overflow: N * (2^WIN-1) * (2^WC-1) < 2^AW
  localparam int AW  = WIN + WC + $clog2(N) + 1;
  // Coefficients carry WC fractional bits; keep WOUT-WIN of them
  localparam int SH  = WC - (WOUT - WIN);
  localparam int D   = (N - 1) / 2;
  localparam int CW  = $clog2(N + 2);
  localparam int AAW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N + 1);

  // Scale the accumulator down to WOUT bits, clipping to all ones
  function automatic logic [WOUT-1:0] sat_f(input logic [AW-1:0] a);
    logic [AW-1:0] s;
    s = a >> SH;
    if ((s >> WOUT) != '0) return '1;
    return s[WOUT-1:0];
  endfunction

  // Widen by replicating the MSBs into the low bits (4'hF -> 6'h3F)
  function automatic logic [WOUT-1:0] ext_f(input logic [WIN-1:0] x);
    logic [WOUT-1:0] r;
    for (int j = 0; j < WOUT; j++) begin
      r[j] = x[WIN - 1 - ((WOUT - 1 - j) % WIN)];
    end
    return r;
  endfunction

  logic [WC-1:0]      coef_q   [N];
  logic [WIN-1:0]     hist_q   [CH][N];
  logic [WIN-1:0]     hist_d   [CH][N];
  logic [AW-1:0]      acc_q    [CH];
  logic [AW-1:0]      acc_d    [CH];
  logic [WIN-1:0]     hist_sel [CH];
  logic [WC+WIN-1:0]  prod     [CH];
  logic [WC-1:0]      coef_sel;
  logic [CW-1:0]      cnt_q;
  logic [CW-1:0]      tap_idx;
  logic               mac_busy;
  logic               en_q;
  logic               lhbl_prev_q;
  logic               ovr_q;
  logic               pxl_out_q;
  logic [CH*WOUT-1:0] rgb_out_q;
  logic               hs_out_q;
  logic               vs_out_q;
  logic               lhbl_out_q;
  // Bit 0 holds the newest sample's sync, bit D the one aligned with the
  // centre tap of the history.
  logic [D:0]         hs_sr_q;
  logic [D:0]         vs_sr_q;
  logic [D:0]         lhbl_sr_q;

  // cnt_q: 0 idle, 1..N accumulating tap cnt-1, N+1 result ready
  assign mac_busy = (cnt_q != '0) && (cnt_q != LAST);

  // History next state, with left/right line-edge clamping
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      for (int i = 0; i < N; i++) begin
        hist_d[c][i] = hist_q[c][i];
      end
    end
    for (int c = 0; c < CH; c++) begin
      if (LHBL_in && !lhbl_prev_q) begin
        for (int i = 0; i < N; i++) begin
          hist_d[c][i] = rgb_in[c*WIN +: WIN];
        end
      end else begin
        hist_d[c][0] = LHBL_in ? rgb_in[c*WIN +: WIN] : hist_q[c][0];
        for (int i = 1; i < N; i++) begin
          hist_d[c][i] = hist_q[c][i-1];
        end
      end
    end
  end

  // Tap selection and one multiply-add per channel
  always_comb begin
    tap_idx  = cnt_q - CW'(1);
    coef_sel = '0;
    for (int c = 0; c < CH; c++) begin
      hist_sel[c] = '0;
    end
    for (int i = 0; i < N; i++) begin
      if (tap_idx == CW'(i)) begin
        coef_sel = coef_q[i];
        for (int c = 0; c < CH; c++) begin
          hist_sel[c] = hist_q[c][i];
        end
      end
    end
    for (int c = 0; c < CH; c++) begin
      prod[c]  = (WC+WIN)'(coef_sel) * (WC+WIN)'(hist_sel[c]);
      acc_d[c] = acc_q[c] + AW'(prod[c]);
    end
  end

  // MAC sequencing, output registers and sync alignment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      en_q        <= 1'b0;
      lhbl_prev_q <= 1'b0;
      ovr_q       <= 1'b0;
      pxl_out_q   <= 1'b0;
      rgb_out_q   <= '0;
      hs_out_q    <= 1'b0;
      vs_out_q    <= 1'b0;
      lhbl_out_q  <= 1'b0;
      hs_sr_q     <= '0;
      vs_sr_q     <= '0;
      lhbl_sr_q   <= '0;
      for (int c = 0; c < CH; c++) begin
        acc_q[c] <= '0;
        for (int i = 0; i < N; i++) begin
          hist_q[c][i] <= '0;
        end
      end
    end else begin
      pxl_out_q <= 1'b0;
      if (cnt_q == LAST) begin
        pxl_out_q  <= 1'b1;
        cnt_q      <= '0;
        hs_out_q   <= hs_sr_q[D];
        vs_out_q   <= vs_sr_q[D];
        lhbl_out_q <= lhbl_sr_q[D];
        for (int c = 0; c < CH; c++) begin
          rgb_out_q[c*WOUT +: WOUT] <= en_q ? sat_f(acc_q[c]) : ext_f(hist_q[c][D]);
        end
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q + CW'(1);
        for (int c = 0; c < CH; c++) begin
          acc_q[c] <= acc_d[c];
        end
      end
      // A new sample always wins; a still-running MAC is simply dropped.
      if (pxl_cen) begin
        if (mac_busy) ovr_q <= 1'b1;
        cnt_q       <= CW'(1);
        en_q        <= enable;
        lhbl_prev_q <= LHBL_in;
        hs_sr_q     <= {hs_sr_q[D-1:0], HS_in};
        vs_sr_q     <= {vs_sr_q[D-1:0], VS_in};
        lhbl_sr_q   <= {lhbl_sr_q[D-1:0], LHBL_in};
        for (int c = 0; c < CH; c++) begin
          acc_q[c] <= '0;
          for (int i = 0; i < N; i++) begin
            hist_q[c][i] <= hist_d[c][i];
          end
        end
      end
    end
  end

`ifdef JTFRAME_HFIR_SHADOW_EN
  logic [WC-1:0] shadow_q [N];
  logic          vs_prev_q;

  // Shadow bank; the active bank is refreshed once per frame at VS rise.
  // A write on the copy clk only reaches the shadow bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_prev_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        shadow_q[i] <= COEFF[i*WC +: WC];
        coef_q[i]   <= COEFF[i*WC +: WC];
      end
    end else begin
      vs_prev_q <= VS_in;
      if (VS_in && !vs_prev_q) begin
        for (int i = 0; i < N; i++) begin
          coef_q[i] <= shadow_q[i];
        end
      end
      if (coef_we) begin
        for (int i = 0; i < N; i++) begin
          if (coef_addr == AAW'(i)) shadow_q[i] <= coef_din;
        end
      end
    end
  end
`else
  logic           pend_vld_q;
  logic [AAW-1:0] pend_addr_q;
  logic [WC-1:0]  pend_val_q;
  logic           wr_ok;

  assign wr_ok = coef_we && (int'(coef_addr) < N);

  // One-entry pending write, applied at the sample boundary so that the
  // coefficients are stable for the whole MAC of a sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
      pend_val_q  <= '0;
      for (int i = 0; i < N; i++) begin
        coef_q[i] <= COEFF[i*WC +: WC];
      end
    end else begin
      if (pxl_cen && pend_vld_q) begin
        pend_vld_q <= 1'b0;
        for (int i = 0; i < N; i++) begin
          if (pend_addr_q == AAW'(i)) coef_q[i] <= pend_val_q;
        end
      end
      if (wr_ok) begin
        pend_vld_q  <= 1'b1;
        pend_addr_q <= coef_addr;
        pend_val_q  <= coef_din;
      end
    end
  end
`endif

  assign pxl_out  = pxl_out_q;
  assign rgb_out  = rgb_out_q;
  assign HS_out   = hs_out_q;
  assign VS_out   = vs_out_q;
  assign LHBL_out = lhbl_out_q;
  assign ovr      = ovr_q;

endmodule

// File: tb/tb_jtframe_hfir.sv
// Directed testbench for jtframe_hfir with default parameters
// (WIN=4, WOUT=6, WC=5, N=5, CH=3, coefficients 0,7,20,7,0).
module tb_jtframe_hfir;
  logic        rst, clk, pxl_cen, enable, HS_in, VS_in, LHBL_in, coef_we;
  logic [11:0] rgb_in;
  logic [2:0]  coef_addr;
  logic [4:0]  coef_din;
  logic        pxl_out, HS_out, VS_out, LHBL_out, ovr;
  logic [17:0] rgb_out;

  int   n_cmp = 0;
  int   n_err = 0;
  int   lat, nstrobe;
  logic obs_hs, obs_vs, obs_lhbl;

  jtframe_hfir #(
    .WIN(4), .WOUT(6), .WC(5), .N(5), .CH(3)
  ) dut (
    .rst(rst), .clk(clk), .pxl_cen(pxl_cen), .enable(enable),
    .rgb_in(rgb_in), .HS_in(HS_in), .VS_in(VS_in), .LHBL_in(LHBL_in),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_din(coef_din),
    .pxl_out(pxl_out), .rgb_out(rgb_out), .HS_out(HS_out), .VS_out(VS_out),
    .LHBL_out(LHBL_out), .ovr(ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] rep(input logic [5:0] v);
    return {v, v, v};
  endfunction

  // Called #1 after a posedge. Issues one pxl_cen with the same pixel on all
  // channels, waits (bounded) for pxl_out and checks latency and value.
  task automatic send(input string tag, input logic [3:0] pix, input logic hs,
                      input logic vs, input logic lhbl, input logic en,
                      input logic [5:0] exp_v);
    int l;
    rgb_in  = {pix, pix, pix};
    HS_in   = hs;
    VS_in   = vs;
    LHBL_in = lhbl;
    enable  = en;
    pxl_cen = 1'b1;
    @(posedge clk); #1;
    pxl_cen = 1'b0;
    l = 0;
    while (pxl_out !== 1'b1 && l < 20) begin
      @(posedge clk); #1;
      l++;
    end
    chk({tag, "_lat"}, 32'(l), 32'd6);
    chk({tag, "_rgb"}, 32'(rgb_out), 32'(rep(exp_v)));
    obs_hs   = HS_out;
    obs_vs   = VS_out;
    obs_lhbl = LHBL_out;
  endtask

  initial begin
    rst = 1'b1; pxl_cen = 1'b0; enable = 1'b1; HS_in = 1'b0; VS_in = 1'b0;
    LHBL_in = 1'b0; coef_we = 1'b0; coef_addr = 3'd0; coef_din = 5'd0;
    rgb_in = 12'h000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pxl_out", 32'(pxl_out), 32'd0);
    chk("rst_rgb_out", 32'(rgb_out), 32'd0);
    chk("rst_lhbl_out", 32'(LHBL_out), 32'd0);
    chk("rst_hs_out", 32'(HS_out), 32'd0);
    chk("rst_vs_out", 32'(VS_out), 32'd0);
    chk("rst_ovr", 32'(ovr), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Flat field (first active sample fills the whole history)
    send("flat1", 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 6'd63);
    chk("flat1_lhbl", 32'(obs_lhbl), 32'd0);
    @(posedge clk); #1;
    chk("strobe_width", 32'(pxl_out), 32'd0);
    send("flat2", 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 6'd63);
    send("flat3", 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 6'd63);
    chk("flat3_lhbl", 32'(obs_lhbl), 32'd1);

    // Flush to zeros
    send("z1", 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd63);
    send("z2", 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd50);
    send("z3", 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd13);
    send("z4", 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0);
    send("z5", 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0);

    // Impulse with HS marking the impulse sample
    send("imp0", 4'hF, 1'b1, 1'b0, 1'b1, 1'b1, 6'd0);
    chk("imp0_hs", 32'(obs_hs), 32'd0);
    send("imp1", 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd13);
    chk("imp1_hs", 32'(obs_hs), 32'd0);
    send("imp2", 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd37);
    chk("imp2_hs", 32'(obs_hs), 32'd1);
    chk("imp2_lhbl", 32'(obs_lhbl), 32'd1);
    send("imp3", 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd13);
    chk("imp3_hs", 32'(obs_hs), 32'd0);
    send("imp4", 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0);

    // Bypass and enable toggling at sample boundaries
    send("byp1", 4'hA, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
    send("byp2", 4'hA, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
    send("byp3", 4'hA, 1'b0, 1'b0, 1'b1, 1'b0, 6'h2A);
    send("byp4", 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd42);
    send("byp5", 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd33);
    send("byp6", 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0);

    // Right edge: blanked samples repeat the last tap-0 value
    send("blk1", 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0);
    chk("blk1_lhbl", 32'(obs_lhbl), 32'd1);
    send("blk2", 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0);

    // Left edge: first active sample fills the history
    send("act1", 4'h8, 1'b0, 1'b0, 1'b1, 1'b1, 6'd34);
    chk("act1_lhbl", 32'(obs_lhbl), 32'd0);
    send("act2", 4'h8, 1'b0, 1'b0, 1'b1, 1'b1, 6'd34);
    chk("act2_lhbl", 32'(obs_lhbl), 32'd0);
    send("act3", 4'h8, 1'b0, 1'b0, 1'b1, 1'b1, 6'd34);
    chk("act3_lhbl", 32'(obs_lhbl), 32'd1);

    // Coefficient load: tap2 = 31, then an out-of-range write that must vanish
    coef_we = 1'b1; coef_addr = 3'd2; coef_din = 5'd31;
    @(posedge clk); #1;
    coef_addr = 3'd6; coef_din = 5'd0;
    @(posedge clk); #1;
    coef_we = 1'b0;
`ifdef JTFRAME_HFIR_SHADOW_EN
    send("cf1", 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 6'd34);
`else
    send("cf1", 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 6'd45);
`endif
    send("cf2", 4'hF, 1'b0, 1'b1, 1'b1, 1'b1, 6'd51);
    send("cf3", 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 6'd63);
    chk("cf3_vs", 32'(obs_vs), 32'd0);
    send("cf4", 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 6'd63);
    chk("cf4_vs", 32'(obs_vs), 32'd1);

    // Overrun: second strobe 4 clk after the first
    chk("ovr_before", 32'(ovr), 32'd0);
    rgb_in = 12'hFFF; pxl_cen = 1'b1;
    @(posedge clk); #1;
    pxl_cen = 1'b0;
    nstrobe = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (pxl_out) nstrobe++;
    end
    pxl_cen = 1'b1;
    @(posedge clk); #1;
    pxl_cen = 1'b0;
    lat = 0;
    while (pxl_out !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ovr_lat", 32'(lat), 32'd6);
    chk("ovr_rgb", 32'(rgb_out), 32'(rep(6'd63)));
    repeat (8) begin
      @(posedge clk); #1;
      if (pxl_out) nstrobe++;
    end
    chk("ovr_extra_strobes", 32'(nstrobe), 32'd0);
    chk("ovr_flag", 32'(ovr), 32'd1);
    send("sticky", 4'h8, 1'b0, 1'b0, 1'b1, 1'b1, 6'd63);
    chk("ovr_sticky", 32'(ovr), 32'd1);

    // Reset in the middle of a MAC
    rgb_in = 12'h888; pxl_cen = 1'b1;
    @(posedge clk); #1;
    pxl_cen = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_ovr", 32'(ovr), 32'd0);
    chk("mid_rst_pxl_out", 32'(pxl_out), 32'd0);
    chk("mid_rst_rgb", 32'(rgb_out), 32'd0);
    chk("mid_rst_lhbl", 32'(LHBL_out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    nstrobe = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (pxl_out) nstrobe++;
    end
    chk("rst_no_strobe", 32'(nstrobe), 32'd0);
    send("post_rst", 4'h8, 1'b0, 1'b0, 1'b1, 1'b1, 6'd34);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
